// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and helpers for the subtractive GCD engine.
// Holds the FSM state enum, default widths and a saturating increment.
package gcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;

  // Returns {hit, next}. hit=1 when v is already at the w-bit
  // all-ones value; next then holds at that value.
  function automatic logic [64:0] sat_inc(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] mx;
    mx = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (v >= mx) return {1'b1, mx};
    return {1'b0, v + 64'd1};
  endfunction

endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: operand registers, compare/subtract, result and counter.
// Ports: i_load/i_step from the FSM, i_a/i_b operands, o_* status/results.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_zero,
  output logic             o_eq,
  output logic [WIDTH-1:0] o_gcd,
  output logic [CNT_W-1:0] o_iter,
  output logic             o_sat,
  output logic             o_zero_in
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_zin;

  logic             w_gt;
  logic [64:0]      w_inc;
  logic             w_unused;

  assign o_zero = (i_a == '0) || (i_b == '0);
  assign o_eq   = (r_a == r_b);
  assign w_gt   = (r_a > r_b);
  assign w_inc  = sat_inc(64'(r_cnt), CNT_W);
  assign w_unused = ^w_inc[63:CNT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
      r_zin <= 1'b0;
    end else if (i_load) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_cnt <= '0;
      r_sat <= 1'b0;
      r_zin <= o_zero;
      // Final answer when an operand is zero; gcd(0,0)=0.
      r_res <= i_a | i_b;
    end else if (i_step) begin
      if (o_eq) begin
        r_res <= r_a;
      end else begin
        // Larger operand is always the minuend: no underflow.
        if (w_gt) r_a <= r_a - r_b;
        else      r_b <= r_b - r_a;
        r_cnt <= w_inc[CNT_W-1:0];
        r_sat <= r_sat | w_inc[64];
      end
    end
  end

  assign o_gcd     = r_res;
  assign o_iter    = r_cnt;
  assign o_sat     = r_sat;
  assign o_zero_in = r_zin;

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: subtractive Euclid GCD with valid/ready on both sides.
// Ports: in_valid/in_ready/a_in/b_in in, out_valid/out_ready/gcd_out out.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_out,
  output logic             iter_sat,
  output logic             zero_in,
  output logic             busy
);

  state_t r_state;
  state_t w_next;
  logic   w_load;
  logic   w_step;
  logic   w_zero;
  logic   w_eq;

  gcd_datapath #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_a      (a_in),
    .i_b      (b_in),
    .o_zero   (w_zero),
    .o_eq     (w_eq),
    .o_gcd    (gcd_out),
    .o_iter   (iter_out),
    .o_sat    (iter_sat),
    .o_zero_in(zero_in)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    in_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load = 1'b1;
          w_next = w_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (w_eq) w_next = S_DONE;
      end
      S_DONE: begin
        // Consuming a result frees the engine in the same cycle.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_load = 1'b1;
            w_next = w_zero ? S_DONE : S_CALC;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_CALC);

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: randomized and directed checks of gcd_engine
// against a quotient-based Euclid reference model.
module tb_gcd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        out_ready = 1'b1;
  logic [15:0] a_in, b_in;
  logic        in_ready, out_valid, busy, iter_sat, zero_in;
  logic [15:0] gcd_out, iter_out;

  logic       in_valid8, out_ready8;
  logic [7:0] a8, b8, gcd8;
  logic [3:0] iter8;
  logic       in_ready8, out_valid8, sat8, zin8, busy8;

  gcd_engine #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .gcd_out(gcd_out), .iter_out(iter_out),
    .iter_sat(iter_sat), .zero_in(zero_in), .busy(busy)
  );

  gcd_engine #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a_in(a8), .b_in(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .gcd_out(gcd8), .iter_out(iter8),
    .iter_sat(sat8), .zero_in(zin8), .busy(busy8)
  );

  int total = 0;
  int bad = 0;
  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Subtraction count = sum of Euclid quotients minus one.
  function automatic void model(
    input longint unsigned a, input longint unsigned b, input int cw,
    output longint unsigned g, output longint unsigned n,
    output longint unsigned lat, output longint unsigned it,
    output bit sat, output bit z);
    longint unsigned x, y, r, mx;
    z = (a == 0) || (b == 0);
    n = 0;
    if (z) begin
      g = a | b;
      lat = 1;
    end else begin
      x = a;
      y = b;
      while (y != 0) begin
        n += x / y;
        r = x % y;
        x = y;
        y = r;
      end
      g = x;
      n = n - 1;
      lat = n + 2;
    end
    mx = (64'd1 << cw) - 1;
    sat = n > mx;
    it = sat ? mx : n;
  endfunction

  typedef struct {
    longint unsigned g, it, ecyc;
    bit sat, z;
  } exp_t;
  exp_t q[$];

  bit prev_ov = 0, prev_or = 0;
  longint unsigned last_g = 0, last_it = 0;
  bit last_s = 0, last_z = 0;
  int mode = 1;

  always begin
    @(negedge clk);
    case (mode)
      0: out_ready = ($urandom_range(3) != 0);
      2: out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  always begin
    exp_t e;
    longint unsigned g, n, lat, it;
    bit s, z;
    @(negedge clk);
    #2;
    if (rst) begin
      q.delete();
      prev_ov = 0;
      prev_or = 0;
    end else begin
      chk("in_ready", in_ready,
          (!out_valid && !busy) || (out_valid && out_ready));
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_result: got gcd %0d want none", gcd_out);
        end else begin
          if (!(prev_ov && !prev_or))
            chk("latency", cyc, q[0].ecyc);
          chk("gcd_out", gcd_out, q[0].g);
          chk("iter_out", iter_out, q[0].it);
          chk("iter_sat", iter_sat, q[0].sat);
          chk("zero_in", zero_in, q[0].z);
          if (out_ready) begin
            last_g = q[0].g;
            last_it = q[0].it;
            last_s = q[0].sat;
            last_z = q[0].z;
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        model(a_in, b_in, 16, g, n, lat, it, s, z);
        e.g = g;
        e.it = it;
        e.sat = s;
        e.z = z;
        e.ecyc = cyc + lat;
        q.push_back(e);
      end
      prev_ov = out_valid;
      prev_or = out_ready;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    #1;
    g = 0;
    while (!in_ready && g < 5000) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready 0 want 1");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_left", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    longint unsigned g, n, lat, it;
    bit s, z;
    int c;
    model(a, b, 4, g, n, lat, it, s, z);
    @(negedge clk);
    in_valid8 = 1'b1;
    a8 = a;
    b8 = b;
    #1;
    chk("w8_ready", in_ready8, 1);
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    c = 1;
    while (!out_valid8 && c < 600) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("w8_latency", c, lat);
    chk("w8_gcd", gcd8, g);
    chk("w8_iter", iter8, it);
    chk("w8_sat", sat8, s);
    chk("w8_zero", zin8, z);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(5))
      0: return 16'd0;
      1: return 16'd1;
      2: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned g, n, lat, it;
    bit s, z;
    logic [15:0] ra, rb;
    int w;

    rst = 1'b1;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    a8 = '0;
    b8 = '0;

    model(48, 18, 16, g, n, lat, it, s, z);
    chk("model_48_18_g", g, 6);
    chk("model_48_18_n", n, 4);
    model(1, 20, 4, g, n, lat, it, s, z);
    chk("model_1_20_it", it, 15);
    chk("model_1_20_sat", s, 1);
    chk("model_1_20_lat", lat, 21);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", iter_sat, 0);
    chk("rst_zero_in", zero_in, 0);
    chk("rst_gcd", gcd_out, 0);
    chk("rst_iter", iter_out, 0);
    chk("rst8_ready", in_ready8, 1);
    chk("rst8_valid", out_valid8, 0);
    @(negedge clk);
    rst = 1'b0;

    mode = 1;
    send(48, 18);
    idle();
    drain();
    chk("t48_gcd", last_g, 6);
    chk("t48_iter", last_it, 4);
    chk("t48_zero", last_z, 0);
    chk("t48_sat", last_s, 0);

    send(12, 12);
    send(0, 35);
    send(0, 0);
    idle();
    drain();
    chk("t00_gcd", last_g, 0);
    chk("t00_zero", last_z, 1);

    mode = 2;
    send(21, 14);
    idle();
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_gcd", gcd_out, 7);
      chk("bp_iter", iter_out, 2);
      @(negedge clk);
      #1;
    end
    mode = 1;
    send(9, 6);
    chk("bp_no_bubble", out_valid, 1);
    idle();
    drain();
    chk("t96_gcd", last_g, 3);
    chk("t96_iter", last_it, 2);

    send(1, 16'hFFFF);
    idle();
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    send(8, 12);
    idle();
    drain();
    chk("t812_gcd", last_g, 4);

    mode = 0;
    for (int i = 0; i < 40; i++) begin
      do begin
        ra = pick();
        rb = pick();
        model(ra, rb, 16, g, n, lat, it, s, z);
      end while (n > 1000);
      if ($urandom_range(2) == 0) idle();
      send(ra, rb);
    end
    idle();
    mode = 1;
    drain();

    run8(1, 20);
    run8(1, 16);
    run8(1, 255);
    run8(0, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised, self-contained GCD engine using the subtractive Euclid algorithm.
- Controller and datapath are merged behind valid/ready handshakes on both operand input and result output.
- Generalises the fixed 16-bit GCD datapath/controller pair:
  - operand width is a parameter;
  - it has a real reset and flow control;
  - zero operands are handled;
  - back-to-back operation is supported;
  - it reports an iteration count.
- Sits between an operand producer (register file or stream) and any result consumer.

Parameters:
- WIDTH, 16, operand and result width in bits (≥2).
- CNT_W, 16, width of the iteration counter (≥1).

Ports:
- clk        input   1        rising-edge clock
- rst        input   1        synchronous reset, active-high
- in_valid   input   1        operand pair valid
- in_ready   output  1        engine can accept an operand pair this cycle
- a_in       input   WIDTH    operand A
- b_in       input   WIDTH    operand B
- out_valid  output  1        result valid
- out_ready  input   1        consumer accepts result
- gcd_out    output  WIDTH    GCD result
- iter_out   output  CNT_W    number of subtract cycles used, saturating
- iter_sat   output  1        iter_out saturated
- zero_in    output  1        at least one accepted operand was zero
- busy       output  1        state is CALC

Behaviour:
- Reset (rst=1 at a clk edge):
  - state←IDLE;
  - in_ready=1 after reset;
  - out_valid, busy, iter_sat, zero_in = 0;
  - gcd_out and iter_out = 0.
  - Reset mid-CALC or mid-DONE aborts the operation; no result is emitted.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational; enables back-to-back operation.
- Accept = in_valid & in_ready at an edge:
  - A←a_in, B←b_in, cnt←0, iter_sat←0;
  - zero_in←(a_in==0 | b_in==0).
  - If a_in==0 or b_in==0: result←a_in|b_in (gcd(0,0)=0), next state DONE.
  - Otherwise next state CALC.
- CALC, one compare/subtract per cycle:
  - A==B: result←A, next DONE.
  - A>B: A←A−B.
  - A<B: B←B−A.
  - Each subtract increments cnt. At all-ones, cnt holds and iter_sat←1.
- Arithmetic:
  - Unsigned, WIDTH bits. The subtraction never underflows because the larger operand is always the minuend.
  - Both operands stay nonzero throughout CALC.
- Latency (handshake cycle = cycle 0, N = subtractions):
  - zero operand: out_valid in cycle 1;
  - otherwise: out_valid in cycle N+2.
- DONE:
  - out_valid=1; gcd_out, iter_out, iter_sat, zero_in held stable until out_valid & out_ready.
  - If out_ready & in_valid in the same cycle: the result is consumed and the new pair is accepted at the same edge (no bubble).
  - If out_ready & !in_valid: next state IDLE.
- Outputs are registered; gcd_out/iter_out are don't-care while out_valid=0 but must not be X after reset.
- in_valid during CALC is ignored (in_ready=0). Operands are not sampled until the handshake.
- Worst case is N = 2^WIDTH−2, e.g. gcd(1, 2^WIDTH−1).

Decomposition:
- gcd_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - default WIDTH/CNT_W localparams;
  - a saturating-increment function.
- One natural sub-module, gcd_datapath:
  - A/B registers, comparator (lt/gt/eq), subtractor, result register, counter;
  - driven by load/step controls from the FSM in gcd_engine.

Test Plan:
- WIDTH=16: a=48,b=18, out_ready=1 → out_valid cycle 6, gcd_out=6, iter_out=4, zero_in=0, iter_sat=0.
- a=12,b=12 → out_valid cycle 2, gcd_out=12, iter_out=0; then a=0,b=35 → out_valid cycle 1, gcd_out=35, zero_in=1; a=0,b=0 → gcd_out=0, zero_in=1.
- CNT_W=4: a=1,b=20 → gcd_out=1, iter_out=15, iter_sat=1; out_valid in cycle 21.
- Back-pressure: a=21,b=14 with out_ready=0 for 5 cycles → gcd_out=7, iter_out=2 held stable and in_ready=0 throughout. Then assert out_ready together with in_valid (a=9,b=6) → accepted the same edge, next result gcd_out=3, iter_out=2, no idle cycle.
- Reset mid-op: accept a=1,b=65535, assert rst during CALC cycle 100 → next cycle in_ready=1, out_valid=0, busy=0, no result emitted; a new pair a=8,b=12 → gcd_out=4.
- Randomised pairs (including 0, 1, 2^WIDTH−1) → gcd_out matches a reference model; iter_out matches the model's subtraction count.
